// File: rtl/instr_encoder.sv
// Packs DP/MEM/BR field bundles into 32-bit words and writes them to a 64-word store.
// Latency: write one cycle after accept; stalls (in_ready=0) while writing or full. Branch support: INSTR_ENCODER_BRANCH_EN.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  cls,
  input  logic [3:0]  cond,
  input  logic [1:0]  dp_cmd,
  input  logic        set_flags,
  input  logic        imm_sel,
  input  logic        load,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [23:0] operand,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [6:0]  count,
  output logic        full,
  output logic        err_illegal
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL_ST} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        legal;
  logic [31:0] enc_word;
  logic [3:0]  cmd4;
  logic [11:0] src2;

`ifndef INSTR_ENCODER_BRANCH_EN
  logic unused_operand_hi;
  assign unused_operand_hi = ^operand[23:12];
`endif

  always_comb begin
    cmd4 = 4'b0000;
    case (dp_cmd)
      2'b00:   cmd4 = 4'b0100;
      2'b01:   cmd4 = 4'b0010;
      2'b10:   cmd4 = 4'b0000;
      default: cmd4 = 4'b1100;
    endcase
    src2 = imm_sel ? {4'h0, operand[7:0]} : {8'h00, operand[3:0]};
  end

  always_comb begin
    legal    = 1'b0;
    enc_word = 32'h0;
    case (cls)
      2'b00: begin
        legal    = 1'b1;
        enc_word = {cond, 2'b00, imm_sel, cmd4, set_flags, rn, rd, src2};
      end
      2'b01: begin
        legal    = 1'b1;
        // immediate offset, pre-index, add, word, no writeback
        enc_word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, operand[11:0]};
      end
`ifdef INSTR_ENCODER_BRANCH_EN
      2'b10: begin
        legal    = 1'b1;
        enc_word = {cond, 2'b10, 2'b10, operand};
      end
`endif
      default: begin
        legal    = 1'b0;
        enc_word = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    full      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!clear && in_valid && legal) state_nxt = WRITE;
      end
      WRITE: begin
        // clear in the write cycle kills the pending word
        wr_en = !clear;
        if (clear)              state_nxt = IDLE;
        else if (count == 7'd63) state_nxt = FULL_ST;
        else                    state_nxt = IDLE;
      end
      FULL_ST: begin
        full = 1'b1;
        if (clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = in_valid && in_ready && !clear;
  assign wr_addr = count[5:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= 7'd0;
      wr_data     <= 32'h0;
      err_illegal <= 1'b0;
    end else begin
      if (clear)               count <= 7'd0;
      else if (state == WRITE) count <= count + 7'd1;

      if (accept && legal) wr_data <= enc_word;

      if (clear)                 err_illegal <= 1'b0;
      else if (accept && !legal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, illegal handling, fill/full, clear and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  cls = 2'b00;
  logic [3:0]  cond = 4'h0;
  logic [1:0]  dp_cmd = 2'b00;
  logic        set_flags = 1'b0;
  logic        imm_sel = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  rn = 4'h0;
  logic [3:0]  rd = 4'h0;
  logic [23:0] operand = 24'h0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  count;
  logic        full;
  logic        err_illegal;

  int total = 0;
  int passed = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .cls(cls), .cond(cond), .dp_cmd(dp_cmd), .set_flags(set_flags), .imm_sel(imm_sel),
    .load(load), .rn(rn), .rd(rd), .operand(operand),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Presents one bundle for one edge; returns 1ns after the accepting edge.
  task automatic send(input logic [1:0] c, input logic [3:0] cd, input logic [1:0] cmd,
                      input logic s, input logic i, input logic l,
                      input logic [3:0] n, input logic [3:0] d, input logic [23:0] op);
    cls = c; cond = cd; dp_cmd = cmd; set_flags = s; imm_sel = i; load = l;
    rn = n; rd = d; operand = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else passed++;
    total++; if (wr_addr !== 6'd0) $display("FAIL rst_wr_addr got %0d want 0", wr_addr); else passed++;
    total++; if (wr_data !== 32'h0) $display("FAIL rst_wr_data got %h want 0", wr_data); else passed++;
    total++; if (count !== 7'd0) $display("FAIL rst_count got %0d want 0", count); else passed++;
    total++; if (full !== 1'b0 || err_illegal !== 1'b0)
      $display("FAIL rst_flags got full=%b err=%b want 0/0", full, err_illegal); else passed++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_dp;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'd5);
    @(negedge clk);
    total++; if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'hE2821005)
      $display("FAIL dp_imm got en=%b addr=%0d data=%h want 1/0/e2821005", wr_en, wr_addr, wr_data); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL dp_busy in_ready got %b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (count !== 7'd1 || wr_en !== 1'b0)
      $display("FAIL dp_count got count=%0d en=%b want 1/0", count, wr_en); else passed++;
    total++; if (wr_data !== 32'hE2821005) $display("FAIL dp_hold got %h want e2821005", wr_data); else passed++;
    @(posedge clk); #1;
    send(2'b00, 4'hE, 2'b01, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 24'd4);
    @(negedge clk);
    total++; if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'hE0533004)
      $display("FAIL dp_reg got en=%b addr=%0d data=%h want 1/1/e0533004", wr_en, wr_addr, wr_data); else passed++;
    @(posedge clk); #1;
    send(2'b00, 4'h1, 2'b11, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 24'hFFF0AB);
    @(negedge clk);
    total++; if (wr_addr !== 6'd2 || wr_data !== 32'h13807_0AB)
      $display("FAIL dp_orr got addr=%0d data=%h want 2/138070ab", wr_addr, wr_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mem;
    send(2'b01, 4'hE, 2'b00, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 24'd8);
    @(negedge clk);
    total++; if (wr_en !== 1'b1 || wr_addr !== 6'd3 || wr_data !== 32'hE5910008)
      $display("FAIL mem_ld got en=%b addr=%0d data=%h want 1/3/e5910008", wr_en, wr_addr, wr_data); else passed++;
    @(posedge clk); #1;
    send(2'b01, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 24'd8);
    @(negedge clk);
    total++; if (wr_en !== 1'b1 || wr_addr !== 6'd4 || wr_data !== 32'hE5810008)
      $display("FAIL mem_st got en=%b addr=%0d data=%h want 1/4/e5810008", wr_en, wr_addr, wr_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_branch_illegal;
    send(2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h000003);
    @(negedge clk);
`ifdef INSTR_ENCODER_BRANCH_EN
    total++; if (wr_en !== 1'b1 || wr_data !== 32'h0A000003)
      $display("FAIL br got en=%b data=%h want 1/0a000003", wr_en, wr_data); else passed++;
    @(posedge clk); #1;
`else
    total++; if (wr_en !== 1'b0 || err_illegal !== 1'b1 || count !== 7'd5 || in_ready !== 1'b1)
      $display("FAIL br_off got en=%b err=%b count=%0d rdy=%b want 0/1/5/1", wr_en, err_illegal, count, in_ready); else passed++;
`endif
    send(2'b11, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 24'd1);
    @(negedge clk);
    total++; if (wr_en !== 1'b0 || err_illegal !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL illegal got en=%b err=%b rdy=%b want 0/1/1", wr_en, err_illegal, in_ready); else passed++;
    // clear and in_valid together: clear wins, bundle dropped
    clear = 1'b1;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'd5);
    clear = 1'b0;
    @(negedge clk);
    total++; if (wr_en !== 1'b0 || count !== 7'd0 || err_illegal !== 1'b0)
      $display("FAIL clr_prio got en=%b count=%0d err=%b want 0/0/0", wr_en, count, err_illegal); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, i);
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== i[5:0]) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad != 0) $display("FAIL fill_addrs got %0d bad writes want 0", bad); else passed++;
    @(negedge clk);
    total++; if (full !== 1'b1 || count !== 7'd64 || in_ready !== 1'b0)
      $display("FAIL full got full=%b count=%0d rdy=%b want 1/64/0", full, count, in_ready); else passed++;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 24'd99);
    @(negedge clk);
    total++; if (wr_en !== 1'b0 || count !== 7'd64 || full !== 1'b1)
      $display("FAIL full_ignore got en=%b count=%0d full=%b want 0/64/1", wr_en, count, full); else passed++;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    total++; if (full !== 1'b0 || count !== 7'd0 || in_ready !== 1'b1)
      $display("FAIL full_clear got full=%b count=%0d rdy=%b want 0/0/1", full, count, in_ready); else passed++;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'd5);
    @(negedge clk);
    total++; if (wr_en !== 1'b1 || wr_addr !== 6'd0)
      $display("FAIL wrap got en=%b addr=%0d want 1/0", wr_en, wr_addr); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear_write;
    send(2'b01, 4'hE, 2'b00, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 24'd8);
    clear = 1'b1;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) $display("FAIL clr_write en got %b want 0", wr_en); else passed++;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    total++; if (count !== 7'd0 || wr_en !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clr_after got count=%0d en=%b rdy=%b want 0/0/1", count, wr_en, in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_write;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'd5);
    @(posedge clk); #1;
    send(2'b00, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'd6);
    #1;
    total++; if (wr_en !== 1'b1 || count !== 7'd1)
      $display("FAIL pre_rst got en=%b count=%0d want 1/1", wr_en, count); else passed++;
    reset = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0 || count !== 7'd0 || wr_data !== 32'h0)
      $display("FAIL mid_rst got en=%b count=%0d data=%h want 0/0/0", wr_en, count, wr_data); else passed++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (wr_en !== 1'b0 || count !== 7'd0 || in_ready !== 1'b1)
      $display("FAIL post_rst got en=%b count=%0d rdy=%b want 0/0/1", wr_en, count, in_ready); else passed++;
  endtask

  initial begin
    test_reset;
    test_dp;
    test_mem;
    test_branch_illegal;
    test_fill;
    test_clear_write;
    test_reset_write;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have: clear  in  1  synchronous restart of the write pointer; in_valid  in  1  field bundle valid; in_ready  out  1  encoder can accept.
REQ-003 SHALL have field inputs: cls  in  2  00=DP, 01=MEM, 10=BR, 11=illegal; cond  in  4; dp_cmd  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR; set_flags  in  1; imm_sel  in  1; load  in  1; rn  in  4; rd  in  4; operand  in  24.
REQ-004 SHALL have outputs: wr_en  out  1; wr_addr  out  6  word address; wr_data  out  32  encoded word; count  out  7  words written; full  out  1; err_illegal  out  1  sticky.

Function
REQ-005 SHALL accept a bundle on a rising clk edge where in_valid and in_ready are both 1; in_ready = 1 only in state IDLE.
REQ-006 SHALL implement FSM IDLE -> WRITE on accept of a legal bundle; WRITE -> IDLE after one cycle when count after the write < 64; WRITE -> FULL when count reaches 64; FULL -> IDLE on clear.
REQ-007 SHALL assert wr_en for exactly the one cycle in WRITE, i.e. the cycle after accept, with wr_addr = count[5:0] and wr_data registered at accept; count increments at the end of WRITE.
REQ-008 SHALL drive wr_en=0 outside WRITE.
REQ-009 SHALL drive wr_data as a stable registered value and SHALL leave it unchanged outside WRITE.
REQ-010 DP encoding SHALL be {cond, 00, imm_sel, cmd4, set_flags, rn, rd, src2}.
REQ-011 In DP, cmd4 SHALL be ADD=0100, SUB=0010, AND=0000, ORR=1100.
REQ-012 In DP, src2 SHALL be {4'h0, operand[7:0]} when imm_sel=1, else {8'h00, operand[3:0]} (Rm, no shift).
REQ-013 MEM encoding SHALL be {cond, 01, 0, 1, 1, 0, 0, load, rn, rd, operand[11:0]}: immediate offset, pre-index, add, word, no writeback.
REQ-014 BR encoding SHALL be {cond, 10, 10, operand[23:0]}.
REQ-015 An accepted illegal bundle (cls=11) SHALL set err_illegal, SHALL NOT write, and SHALL leave the state in IDLE.
REQ-016 full SHALL be 1 exactly in state FULL; in FULL, in_ready=0.
REQ-017 clear SHALL force state IDLE, count=0 and err_illegal=0 from any state; clear has priority over a simultaneous in_valid, which is not accepted.
REQ-018 clear asserted during WRITE SHALL suppress that write: wr_en=0 from the edge at which clear is sampled.
REQ-019 wr_addr SHALL wrap 63 -> 0 only through clear, never by count overflow.

Reset
REQ-020 While reset=0, SHALL immediately force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0 and err_illegal=0; in_ready=1 after reset release.
REQ-021 reset asserted mid-WRITE SHALL drop wr_en asynchronously, and the pending word SHALL be discarded.

Configuration
REQ-022 Macro INSTR_ENCODER_BRANCH_EN: when defined, cls=10 SHALL encode per REQ-014; when undefined, cls=10 SHALL be treated as illegal per REQ-015 and no branch logic SHALL be synthesized.

Verification
REQ-023 DP immediate: cls=00, cond=E, dp_cmd=00, S=0, imm_sel=1, rn=2, rd=1, operand=5 -> next cycle wr_en=1, wr_addr=0, wr_data=0xE2821005, and count=1 the cycle after.
REQ-024 DP register with S: dp_cmd=01, S=1, imm_sel=0, rn=3, rd=3, operand=4, cond=E -> wr_data=0xE0533004; then MEM load=1, rn=1, rd=0, operand=8 -> 0xE5910008 at wr_addr=1; with load=0 -> 0xE5810008.
REQ-025 Branch (macro defined): cls=10, cond=0, operand=0x000003 -> wr_data=0x0A000003. Macro undefined: same stimulus -> wr_en stays 0, err_illegal=1, and count is unchanged.
REQ-026 Fill: 64 back-to-back legal bundles -> last write at wr_addr=63, then full=1, count=64 and in_ready=0; a 65th in_valid is ignored; clear -> full=0, count=0, in_ready=1, and the next write goes to wr_addr=0.
REQ-027 Reset and clear mid-operation: reset=0 during WRITE -> wr_en=0 immediately and count=0; in a separate run, clear during WRITE -> no write occurs and count=0.
